// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// ALU operation codes and the bit positions of the {N,Z,C,V} flags.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FLAGS_W = 4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_ORR = 2'd3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Pulls the carry bit out of an ALU flag vector
  function automatic logic flag_carry(input logic [FLAGS_W-1:0] flags);
    return flags[FLAG_C];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the request, ALU and response signals around the arbiter.
// The slave view is the arbiter itself; the master view is everything
// around it (both requesters plus the ALU).
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 2
);
  import alu_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_src_a;
  logic [WIDTH-1:0]  req0_src_b;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_src_a;
  logic [WIDTH-1:0]  req1_src_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic [WIDTH-1:0]  alu_src_a;
  logic [WIDTH-1:0]  alu_src_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_carry;
  logic [WIDTH-1:0]  alu_result;
  logic [FLAGS_W-1:0] alu_flags;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [WIDTH-1:0]  rsp_result;
  logic [FLAGS_W-1:0] rsp_flags;

  modport slave (
    input  req0_valid, req0_src_a, req0_src_b, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_src_a, req1_src_b, req1_ctrl,
    output req1_ready,
    output alu_src_a, alu_src_b, alu_ctrl, alu_carry,
    input  alu_result, alu_flags,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_flags
  );

  modport master (
    output req0_valid, req0_src_a, req0_src_b, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_src_a, req1_src_b, req1_ctrl,
    input  req1_ready,
    input  alu_src_a, alu_src_b, alu_ctrl, alu_carry,
    output alu_result, alu_flags,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. Purely combinational: when both requesters
// are valid the one that did not win last time gets the grant. The
// last_grant history register belongs to the caller.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Pick the winner id, then expand it to a one-hot grant if anyone asked
  always_comb begin
    grant_id = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
    grant = {grant_id, ~grant_id} & {2{valid0 | valid1}};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. An accepted op is registered,
// presented to the ALU for one cycle, and its result/flags come back as a
// one-cycle response pulse to the owner. Each requester keeps its own saved
// carry so add-with-carry chains from one never leak into the other.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          clr,
  alu_arbiter_if.slave  bus
);

  state_t              state;
  logic                owner;
  logic                last_grant;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [CTRL_W-1:0]   op_ctrl;
  logic [1:0]          saved_carry;
  logic [WIDTH-1:0]    result_q;
  logic [FLAGS_W-1:0]  flags_q;
  logic                rsp0_q;
  logic                rsp1_q;
  logic [1:0]          grant;
  logic                grant_id;
  logic                can_accept;

  rr_arb2 u_rr_arb2 (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Ready only ever goes to the winner, only in IDLE, never during reset or clr
  assign can_accept     = RESET_N && !clr && (state == ST_IDLE);
  assign bus.req0_ready = can_accept && grant[0];
  assign bus.req1_ready = can_accept && grant[1];

  assign bus.alu_src_a  = op_a;
  assign bus.alu_src_b  = op_b;
  assign bus.alu_ctrl   = op_ctrl;
  assign bus.alu_carry  = (state == ST_EXEC) ? saved_carry[owner] : 1'b0;

  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;

  // Control FSM plus all operand, result and carry registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      saved_carry <= 2'b00;
      result_q    <= '0;
      flags_q     <= '0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
    end else if (clr) begin
      state       <= ST_IDLE;
      saved_carry <= 2'b00;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          if (grant != 2'b00) begin
            if (grant_id) begin
              op_a    <= bus.req1_src_a;
              op_b    <= bus.req1_src_b;
              op_ctrl <= bus.req1_ctrl;
            end else begin
              op_a    <= bus.req0_src_a;
              op_b    <= bus.req0_src_b;
              op_ctrl <= bus.req0_ctrl;
            end
            owner <= grant_id;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q           <= bus.alu_result;
          flags_q            <= bus.alu_flags;
          saved_carry[owner] <= flag_carry(bus.alu_flags);
          rsp0_q             <= ~owner;
          rsp1_q             <= owner;
          state              <= ST_RESP;
        end
        ST_RESP: begin
          rsp0_q     <= 1'b0;
          rsp1_q     <= 1'b0;
          last_grant <= owner;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
// The ALU adds the Carry input on ADD (add-with-carry) so the per-requester
// saved carry shows up in results as well as on alu_carry.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.WIDTH(32), .CTRL_W(2)) bus ();

  alu_arbiter #(.WIDTH(32), .CTRL_W(2)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (clr),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  logic [32:0] alu_sum;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;

  // Reference ALU: ADD (with carry in), SUB, AND, ORR with {N,Z,C,V} flags
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD: begin
        alu_sum = {1'b0, bus.alu_src_a} + {1'b0, bus.alu_src_b} + {32'd0, bus.alu_carry};
        alu_res = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (bus.alu_src_a[31] == bus.alu_src_b[31]) && (alu_res[31] != bus.alu_src_a[31]);
      end
      OP_SUB: begin
        alu_sum = {1'b0, bus.alu_src_a} + {1'b0, ~bus.alu_src_b} + 33'd1;
        alu_res = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (bus.alu_src_a[31] != bus.alu_src_b[31]) && (alu_res[31] != bus.alu_src_a[31]);
      end
      OP_AND:  alu_res = bus.alu_src_a & bus.alu_src_b;
      default: alu_res = bus.alu_src_a | bus.alu_src_b;
    endcase
    bus.alu_result = alu_res;
    bus.alu_flags  = {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
  end

  // Drive both request channels in one go
  task automatic apply_stimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [1:0] c0, input logic v1, input logic [31:0] a1,
                                input logic [31:0] b1, input logic [1:0] c1);
    bus.req0_valid = v0;
    bus.req0_src_a = a0;
    bus.req0_src_b = b0;
    bus.req0_ctrl  = c0;
    bus.req1_valid = v1;
    bus.req1_src_a = a1;
    bus.req1_src_b = b1;
    bus.req1_ctrl  = c1;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0, 32'd0, 32'd0, OP_ADD);
  endtask

  task automatic test_reset();
    apply_stimulus(1'b1, 32'd9, 32'd9, OP_SUB, 1'b1, 32'd8, 32'd8, OP_ORR);
    #2;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready0: got %0b want 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready1: got %0b want 0", bus.req1_ready); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp0: got %0b want 0", bus.rsp0_valid); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp1: got %0b want 0", bus.rsp1_valid); end
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL rst_carry: got %0b want 0", bus.alu_carry); end
    checks++; if (bus.alu_src_a !== 32'd0) begin errors++; $display("[TB] FAIL rst_src_a: got %h want 0", bus.alu_src_a); end
    checks++; if (bus.alu_ctrl !== 2'd0) begin errors++; $display("[TB] FAIL rst_ctrl: got %0d want 0", bus.alu_ctrl); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL rst_result: got %h want 0", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'd0) begin errors++; $display("[TB] FAIL rst_flags: got %b want 0000", bus.rsp_flags); end
    @(negedge CLK);
    apply_idle();
    RESET_N = 1'b1;
  endtask

  // Both requesters held valid for four ops: grant order 0,1,0,1
  task automatic test_back_to_back();
    logic [31:0] exp_res [2];
    logic [3:0]  exp_flg [2];
    exp_res[0] = 32'h0000_00A5; exp_flg[0] = 4'b0000;
    exp_res[1] = 32'hF0F0_0000; exp_flg[1] = 4'b1000;
    @(negedge CLK);
    apply_stimulus(1'b1, 32'h0000_00A0, 32'h0000_0005, OP_ORR,
                   1'b1, 32'hFFFF_0000, 32'hF0F0_F0F0, OP_AND);
    for (int k = 0; k < 12; k++) begin
      int ph;
      int id;
      if (k > 0) @(negedge CLK);
      #1;
      ph = k % 3;
      id = (k / 3) % 2;
      checks++; if (bus.req0_ready !== (ph == 0 && id == 0)) begin errors++; $display("[TB] FAIL b2b_ready0[%0d]: got %0b want %0b", k, bus.req0_ready, (ph == 0 && id == 0)); end
      checks++; if (bus.req1_ready !== (ph == 0 && id == 1)) begin errors++; $display("[TB] FAIL b2b_ready1[%0d]: got %0b want %0b", k, bus.req1_ready, (ph == 0 && id == 1)); end
      checks++; if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin errors++; $display("[TB] FAIL b2b_both_ready[%0d]: got 1 want 0", k); end
      checks++; if (bus.rsp0_valid !== (ph == 2 && id == 0)) begin errors++; $display("[TB] FAIL b2b_rsp0[%0d]: got %0b want %0b", k, bus.rsp0_valid, (ph == 2 && id == 0)); end
      checks++; if (bus.rsp1_valid !== (ph == 2 && id == 1)) begin errors++; $display("[TB] FAIL b2b_rsp1[%0d]: got %0b want %0b", k, bus.rsp1_valid, (ph == 2 && id == 1)); end
      if (ph == 2) begin
        checks++; if (bus.rsp_result !== exp_res[id]) begin errors++; $display("[TB] FAIL b2b_result[%0d]: got %h want %h", k, bus.rsp_result, exp_res[id]); end
        checks++; if (bus.rsp_flags !== exp_flg[id]) begin errors++; $display("[TB] FAIL b2b_flags[%0d]: got %b want %b", k, bus.rsp_flags, exp_flg[id]); end
      end
    end
    @(negedge CLK);
    apply_idle();
  endtask

  // Lone req0 ADD 5,7: ready at T, response at T+2, result held afterwards
  task automatic test_single_add();
    @(negedge CLK);
    apply_stimulus(1'b1, 32'd5, 32'd7, OP_ADD, 1'b0, 32'd0, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready0: got %0b want 1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_ready1: got %0b want 0", bus.req1_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_src_a !== 32'd5) begin errors++; $display("[TB] FAIL add_src_a: got %h want 5", bus.alu_src_a); end
    checks++; if (bus.alu_src_b !== 32'd7) begin errors++; $display("[TB] FAIL add_src_b: got %h want 7", bus.alu_src_b); end
    checks++; if (bus.alu_ctrl !== OP_ADD) begin errors++; $display("[TB] FAIL add_ctrl: got %0d want 0", bus.alu_ctrl); end
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL add_carry: got %0b want 0", bus.alu_carry); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp0_early: got %0b want 0", bus.rsp0_valid); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_rsp0: got %0b want 1", bus.rsp0_valid); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp1: got %0b want 0", bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 32'd12) begin errors++; $display("[TB] FAIL add_result: got %h want 0000000c", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'b0000) begin errors++; $display("[TB] FAIL add_flags: got %b want 0000", bus.rsp_flags); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp0_pulse: got %0b want 0", bus.rsp0_valid); end
    checks++; if (bus.rsp_result !== 32'd12) begin errors++; $display("[TB] FAIL add_result_hold: got %h want 0000000c", bus.rsp_result); end
  endtask

  // SUB 3,3 sets C0; req1 must not see it, req0's next ADD must
  task automatic test_sub_carry();
    @(negedge CLK);
    apply_stimulus(1'b1, 32'd3, 32'd3, OP_SUB, 1'b0, 32'd0, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL sub_ready0: got %0b want 1", bus.req0_ready); end
    @(negedge CLK);
    apply_idle();
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL sub_rsp0: got %0b want 1", bus.rsp0_valid); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL sub_result: got %h want 0", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'b0110) begin errors++; $display("[TB] FAIL sub_flags: got %b want 0110", bus.rsp_flags); end
    @(negedge CLK);
    apply_stimulus(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 32'h0000_00FF, 32'h0000_000F, OP_AND);
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL sub_and_ready1: got %0b want 1", bus.req1_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL sub_req1_carry: got %0b want 0", bus.alu_carry); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp1_valid !== 1'b1) begin errors++; $display("[TB] FAIL sub_and_rsp1: got %0b want 1", bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 32'h0000_000F) begin errors++; $display("[TB] FAIL sub_and_result: got %h want 0000000f", bus.rsp_result); end
    @(negedge CLK);
    apply_stimulus(1'b1, 32'd1, 32'd1, OP_ADD, 1'b0, 32'd0, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL adc_ready0: got %0b want 1", bus.req0_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_carry !== 1'b1) begin errors++; $display("[TB] FAIL adc_carry: got %0b want 1", bus.alu_carry); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL adc_rsp0: got %0b want 1", bus.rsp0_valid); end
    checks++; if (bus.rsp_result !== 32'd3) begin errors++; $display("[TB] FAIL adc_result: got %h want 3", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'b0000) begin errors++; $display("[TB] FAIL adc_flags: got %b want 0000", bus.rsp_flags); end
  endtask

  // req1 overflowing ADD sets C1; the following req0 op still sees carry 0
  task automatic test_carry_isolation();
    @(negedge CLK);
    apply_stimulus(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_ADD);
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL iso_ready1: got %0b want 1", bus.req1_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL iso_carry1: got %0b want 0", bus.alu_carry); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp1_valid !== 1'b1) begin errors++; $display("[TB] FAIL iso_rsp1: got %0b want 1", bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL iso_result1: got %h want 0", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'b0110) begin errors++; $display("[TB] FAIL iso_flags1: got %b want 0110", bus.rsp_flags); end
    @(negedge CLK);
    apply_stimulus(1'b1, 32'd2, 32'd3, OP_ADD, 1'b0, 32'd0, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL iso_ready0: got %0b want 1", bus.req0_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL iso_carry0: got %0b want 0", bus.alu_carry); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp_result !== 32'd5) begin errors++; $display("[TB] FAIL iso_result0: got %h want 5", bus.rsp_result); end
  endtask

  // clr in EXEC of a req1 op: no response, IDLE next cycle, carries cleared;
  // clr in IDLE blocks acceptance
  task automatic test_clr();
    @(negedge CLK);
    apply_stimulus(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 32'd1, 32'd2, OP_ORR);
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL clr_ready1: got %0b want 1", bus.req1_ready); end
    @(negedge CLK);
    apply_idle();
    clr = 1'b1;
    #1;
    checks++; if (bus.alu_src_a !== 32'd1) begin errors++; $display("[TB] FAIL clr_exec_src_a: got %h want 1", bus.alu_src_a); end
    checks++; if (bus.alu_carry !== 1'b1) begin errors++; $display("[TB] FAIL clr_exec_carry: got %0b want 1", bus.alu_carry); end
    @(negedge CLK);
    clr = 1'b0;
    apply_stimulus(1'b1, 32'd0, 32'd0, OP_ADD, 1'b0, 32'd0, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_no_rsp1: got %0b want 0", bus.rsp1_valid); end
    checks++; if (bus.rsp_result !== 32'd5) begin errors++; $display("[TB] FAIL clr_result_kept: got %h want 5", bus.rsp_result); end
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL clr_idle_ready0: got %0b want 1", bus.req0_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL clr_carry0: got %0b want 0", bus.alu_carry); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_rsp0: got %0b want 1", bus.rsp0_valid); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_rsp1_late: got %0b want 0", bus.rsp1_valid); end
    checks++; if (bus.rsp_flags !== 4'b0100) begin errors++; $display("[TB] FAIL clr_zero_flags: got %b want 0100", bus.rsp_flags); end
    @(negedge CLK);
    apply_stimulus(1'b0, 32'd0, 32'd0, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL clr_ready1b: got %0b want 1", bus.req1_ready); end
    @(negedge CLK);
    apply_idle();
    #1;
    checks++; if (bus.alu_carry !== 1'b0) begin errors++; $display("[TB] FAIL clr_carry1_cleared: got %0b want 0", bus.alu_carry); end
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp_result !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL clr_result1: got %h want ffffffff", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'b1000) begin errors++; $display("[TB] FAIL clr_flags1: got %b want 1000", bus.rsp_flags); end
    @(negedge CLK);
    apply_stimulus(1'b1, 32'd9, 32'd9, OP_ADD, 1'b0, 32'd0, 32'd0, OP_ADD);
    clr = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_idle_block: got %0b want 0", bus.req0_ready); end
    @(negedge CLK);
    clr = 1'b0;
    apply_idle();
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_no_accept: got %0b want 0", bus.rsp0_valid); end
  endtask

  // Reset during RESP kills the pulse and everything else; req0 wins after
  task automatic test_reset_mid();
    @(negedge CLK);
    apply_stimulus(1'b1, 32'h0000_000F, 32'h0000_000F, OP_AND, 1'b0, 32'd0, 32'd0, OP_ADD);
    @(negedge CLK);
    apply_idle();
    @(negedge CLK);
    @(negedge CLK);
    apply_stimulus(1'b1, 32'h0000_0010, 32'h0000_0001, OP_ORR, 1'b0, 32'd0, 32'd0, OP_ADD);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready0: got %0b want 1", bus.req0_ready); end
    @(negedge CLK);
    apply_idle();
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_rsp0: got %0b want 1", bus.rsp0_valid); end
    checks++; if (bus.rsp_result !== 32'h0000_0011) begin errors++; $display("[TB] FAIL rmid_result: got %h want 00000011", bus.rsp_result); end
    RESET_N = 1'b0;
    apply_stimulus(1'b1, 32'd4, 32'd4, OP_ADD, 1'b1, 32'h0000_000F, 32'h0000_0003, OP_AND);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rsp0_drop: got %0b want 0", bus.rsp0_valid); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL rmid_result_zero: got %h want 0", bus.rsp_result); end
    checks++; if (bus.rsp_flags !== 4'd0) begin errors++; $display("[TB] FAIL rmid_flags_zero: got %b want 0000", bus.rsp_flags); end
    checks++; if (bus.alu_src_a !== 32'd0) begin errors++; $display("[TB] FAIL rmid_src_a_zero: got %h want 0", bus.alu_src_a); end
    checks++; if (bus.alu_ctrl !== 2'd0) begin errors++; $display("[TB] FAIL rmid_ctrl_zero: got %0d want 0", bus.alu_ctrl); end
    checks++; if ((bus.req0_ready | bus.req1_ready) !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ready_in_reset: got 1 want 0"); end
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_first_ready0: got %0b want 1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_first_ready1: got %0b want 0", bus.req1_ready); end
    @(negedge CLK);
    apply_idle();
    @(negedge CLK);
    #1;
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_post_rsp0: got %0b want 1", bus.rsp0_valid); end
    checks++; if (bus.rsp_result !== 32'd8) begin errors++; $display("[TB] FAIL rmid_post_result: got %h want 8", bus.rsp_result); end
  endtask

  // Top-level sequence
  initial begin
    test_reset();
    test_back_to_back();
    test_single_add();
    test_sub_carry();
    test_carry_isolation();
    test_clr();
    test_reset_mid();
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a run that never ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
